// File: rtl/watch_pkg.sv
`default_nettype none
// ============================================================================
// Module : watch_pkg
// Purpose: Shared definitions for the watch front-end and the mode blocks
//          (stopwatch, clock, timer) that consume its state/flag outputs.
//          Holds the display-mode encoding, the one-cycle command codes and
//          the board button indices.
// Rev    : 1.0  initial release
// ============================================================================
package watch_pkg;

  // Display mode, carried on the 4-bit state bus.
  typedef enum logic [3:0] {
    MODE_CLOCK = 4'd0,
    MODE_SW    = 4'd1,
    MODE_TMR   = 4'd2
  } mode_t;

  // Command codes carried on the 4-bit flag bus; FLG_NONE means idle.
  localparam logic [3:0] FLG_NONE     = 4'd0;
  localparam logic [3:0] FLG_HOUR_INC = 4'd1;
  localparam logic [3:0] FLG_MIN_INC  = 4'd2;
  localparam logic [3:0] FLG_TMR_SET  = 4'd3;
  localparam logic [3:0] FLG_TMR_GO   = 4'd4;
  localparam logic [3:0] FLG_SW_CLEAR = 4'd5;
  localparam logic [3:0] FLG_SW_STOP  = 4'd6;
  localparam logic [3:0] FLG_SW_START = 4'd7;

  // Positions of the functional buttons inside the raw button vector.
  localparam int BTN_MODE = 0;
  localparam int BTN_A    = 1;
  localparam int BTN_B    = 2;

  // Mode sequence on a MODE press; any stray encoding recovers to CLOCK.
  function automatic mode_t next_mode(input mode_t cur);
    mode_t nxt;
    case (cur)
      MODE_CLOCK: nxt = MODE_SW;
      MODE_SW:    nxt = MODE_TMR;
      default:    nxt = MODE_CLOCK;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module : btn_debounce
// Purpose: One raw button: 2-flop synchroniser, counter debouncer and a
//          registered rising-edge detector producing a one-cycle press pulse.
// Ports  : clk      in  system clock
//          rst_n    in  asynchronous active-low reset
//          btn_raw  in  raw asynchronous active-high button
//          press    out one-cycle pulse per debounced press (not on release)
// Rev    : 1.0  initial release
// ============================================================================
module btn_debounce
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16,
  parameter int CNT_W        = $clog2(DEBOUNCE_CYC + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    level_d     = level_q;
    cnt_d       = '0;
    level_dly_d = level_q;
    // Registered so that the pulse leaves this block one cycle after the
    // debounced level rises.
    press_d     = level_q & ~level_dly_q;
    // The counter only runs while the synchronised input disagrees with the
    // debounced level; any agreeing sample restarts it, so a glitch shorter
    // than DEBOUNCE_CYC samples can never move the level.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
      cnt_q       <= cnt_d;
    end
  end

  assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/watch_btn_ctrl.sv
`default_nettype none
// ============================================================================
// Module : watch_btn_ctrl
// Purpose: Watch front-end. Debounces the raw board buttons, holds the
//          display mode and turns presses into one-cycle command codes for
//          the mode blocks.
// Ports  : clk        in  system clock
//          rst_n      in  asynchronous active-low reset
//          btn        in  [N_BTN] raw buttons (0=MODE, 1=A, 2=B, rest spare)
//          state      out [4] current mode (0 CLOCK, 1 STOPWATCH, 2 TIMER)
//          flag       out [4] one-cycle command code, 0 when idle
//          sw_running out stopwatch run status as last commanded
// Rev    : 1.0  initial release
// ============================================================================
module watch_btn_ctrl
  import watch_pkg::*;
#(
  parameter int N_BTN        = 8,
  parameter int DEBOUNCE_CYC = 16,
  parameter int CNT_W        = $clog2(DEBOUNCE_CYC + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn,
  output logic [3:0]       state,
  output logic [3:0]       flag,
  output logic             sw_running
);

  logic [N_BTN-1:0] press;

  // Every button gets the same front-end, including the spare ones.
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W)
    ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn[i]),
      .press   (press[i])
    );
  end

  // Spare buttons are conditioned but deliberately decode to nothing.
  if (N_BTN > 3) begin : g_spare
    logic unused_press;
    assign unused_press = ^press[N_BTN-1:3];
  end

  mode_t      state_q, state_d;
  logic [3:0] flag_q, flag_d;
  logic       sw_running_q, sw_running_d;

  // Priority MODE > A > B; a press that loses in its cycle is simply dropped.
  always_comb begin
    state_d      = state_q;
    flag_d       = FLG_NONE;
    sw_running_d = sw_running_q;
    if (press[BTN_MODE]) begin
      state_d = next_mode(state_q);
    end else if (press[BTN_A]) begin
      case (state_q)
        MODE_CLOCK: flag_d = FLG_HOUR_INC;
        MODE_SW: begin
          flag_d       = sw_running_q ? FLG_SW_STOP : FLG_SW_START;
          sw_running_d = ~sw_running_q;
        end
        MODE_TMR:   flag_d = FLG_TMR_SET;
        default:    flag_d = FLG_NONE;
      endcase
    end else if (press[BTN_B]) begin
      case (state_q)
        MODE_CLOCK: flag_d = FLG_MIN_INC;
        MODE_SW:    flag_d = FLG_SW_CLEAR;
        MODE_TMR:   flag_d = FLG_TMR_GO;
        default:    flag_d = FLG_NONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= MODE_CLOCK;
      flag_q       <= FLG_NONE;
      sw_running_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flag_q       <= flag_d;
      sw_running_q <= sw_running_d;
    end
  end

  assign state      = state_q;
  assign flag       = flag_q;
  assign sw_running = sw_running_q;

endmodule
`default_nettype wire
